// File: rtl/sm_lsu_if.sv
// Bus bundles for the load/store unit: the core-facing request/response channel
// and the word-addressed valid/ack data-memory channel.
interface sm_lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_da;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  // master = execute stage issuing accesses, slave = the LSU
  modport master (
    output req_valid, req_we, req_da, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_da, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface sm_lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // master = the LSU, slave = data memory
  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/sm_lsu.sv
// Load/store unit: turns byte/halfword/word core accesses into word-addressed
// valid/ack bus transfers with lane strobes, load extension, misalign and timeout detection.
module sm_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  sm_lsu_core_if.slave core,
  sm_lsu_mem_if.master mem
);

  // Alignment codes follow the RISC-V funct3 size field; the spare code acts as word.
  localparam logic [1:0] DA_BYTE = 2'b00;
  localparam logic [1:0] DA_HALF = 2'b01;

  localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             we_q, we_d;
  logic [1:0]       da_q, da_d;
  logic             uns_q, uns_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             in_bus;
  logic             in_resp;

  function automatic logic is_misaligned(input logic [1:0] da, input logic [1:0] a);
    logic bad;
    case (da)
      DA_BYTE: bad = 1'b0;
      DA_HALF: bad = a[0];
      default: bad = (a != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] da, input logic [1:0] a);
    logic [3:0] be;
    case (da)
      DA_BYTE: be = 4'b0001 << a;
      DA_HALF: be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] da, input logic [31:0] wd);
    logic [31:0] d;
    case (da)
      DA_BYTE: d = {4{wd[7:0]}};
      DA_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] da, input logic uns,
                                              input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (da)
      DA_BYTE: r = {{24{~uns & b[7]}}, b};
      DA_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    da_d    = da_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (core.req_valid) begin
          we_d    = core.req_we;
          da_d    = core.req_da;
          uns_d   = core.req_unsigned;
          addr_d  = core.req_addr;
          wdata_d = core.req_wdata;
          cnt_d   = '0;
          // Misaligned requests are answered without ever touching the bus.
          if (is_misaligned(core.req_da, core.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // An ack arriving on the final allowed cycle still completes the access.
        if (mem.mem_ack) begin
          rdata_d = mem.mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request payload and read data are only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    da_q    <= da_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign in_bus  = (state_q == S_BUS);
  assign in_resp = (state_q == S_RESP);

  assign core.req_ready = (state_q == S_IDLE);
  assign core.rsp_valid = in_resp;
  assign core.rsp_err   = in_resp & err_q;
  assign core.rsp_rdata = (in_resp && !we_q && !err_q)
                          ? load_extend(da_q, uns_q, addr_q[1:0], rdata_q) : 32'h0;

  assign mem.mem_req   = in_bus;
  assign mem.mem_we    = in_bus & we_q;
  assign mem.mem_be    = in_bus ? lane_be(da_q, addr_q[1:0]) : 4'h0;
  assign mem.mem_addr  = in_bus ? addr_q[31:2] : 30'h0;
  assign mem.mem_wdata = (in_bus && we_q) ? lane_wdata(da_q, wdata_q) : 32'h0;

endmodule
